// File: rtl/rom_word_serializer.sv
// -----------------------------------------------------------------------------
// rom_word_serializer
//
// Drives the address bus of a small word ROM and streams its contents off-chip
// as a single serial bitstream. A transfer is either one word (manual_en=1) or
// a whole frame starting at address 0. Each word is fetched and then shifted
// out MSB-first under valid/ready flow control.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   start        begin a transfer (looked at only while idle)
//   abort        cancel a transfer in progress, no done pulse
//   manual_en    1 = single word at manual_addr, 0 = full frame from 0
//   manual_addr  word address used in single-word mode
//   rom_addr     registered ROM address
//   rom_data     ROM word, valid ROM_LAT cycles after rom_addr changes
//   ser_out      serial data bit (0 whenever ser_valid is low)
//   ser_valid    ser_out carries a bit
//   ser_ready    downstream takes the bit when ser_valid && ser_ready
//   word_sync    marks the first bit of every word
//   frame_sync   marks the first bit of word 0 in full-frame mode
//   busy         a transfer is in progress (fetching or shifting)
//   done         one-cycle pulse after the last bit of a normal transfer
//
// ROM_LAT must lie in 0..3; the fetch wait counter is two bits wide.
// -----------------------------------------------------------------------------
module rom_word_serializer #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              manual_en,
    input  logic [ADDR_W-1:0] manual_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              word_sync,
    output logic              frame_sync,
    output logic              busy,
    output logic              done
);

    // The bit counter must be able to hold DATA_W, the value it reaches after
    // the final bit of a word is accepted.
    localparam int                CNT_W     = $clog2(DATA_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(ROM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [1:0]         wait_q, wait_d;
    logic               manual_q, manual_d;

    logic accept;
    logic fetch_last;
    logic word_last;
    logic frame_last;

    assign accept     = (state_q == S_SHIFT) && ser_ready;
    assign fetch_last = (wait_q == LAT_LAST);
    assign word_last  = (bitcnt_q == LAST_BIT);
    // The frame ends on its last address; the address never wraps.
    assign frame_last = manual_q || (addr_q == LAST_ADDR);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (fetch_last) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept && word_last) begin
                    state_d = frame_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: address, mode, fetch wait, shifter and bit count
    // -------------------------------------------------------------------------
    always_comb begin
        addr_d   = addr_q;
        manual_d = manual_q;
        wait_d   = wait_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    manual_d = manual_en;
                    addr_d   = manual_en ? manual_addr : '0;
                    wait_d   = 2'd0;
                end
            end
            S_FETCH: begin
                // rom_addr is held for the whole fetch; the word is captured
                // on the edge that closes the last fetch cycle.
                if (!abort) begin
                    if (fetch_last) begin
                        shreg_d  = rom_data;
                        bitcnt_d = '0;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
            end
            S_SHIFT: begin
                if (!abort && accept) begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q + 1'b1;
                    // Advance the address on the same edge as the last bit so
                    // the next fetch starts with a stable address.
                    if (word_last && !frame_last) begin
                        addr_d = addr_q + 1'b1;
                        wait_d = 2'd0;
                    end
                end
            end
            S_DONE: begin
                // rom_addr keeps its final value until the next start.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            manual_q <= 1'b0;
            wait_q   <= 2'd0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            addr_q   <= addr_d;
            manual_q <= manual_d;
            wait_q   <= wait_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registered state only, so ser_ready never reaches
    // ser_valid combinationally. During a stall every register feeding these
    // outputs holds, so the outputs hold too.
    // -------------------------------------------------------------------------
    always_comb begin
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE:  ;
            S_FETCH: busy = 1'b1;
            S_SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
            end
            S_DONE:  done = 1'b1;
        endcase
        ser_out    = ser_valid & shreg_q[DATA_W-1];
        word_sync  = ser_valid && (bitcnt_q == '0);
        frame_sync = word_sync && !manual_q && (addr_q == '0);
        rom_addr   = addr_q;
    end

endmodule

// File: tb/tb_rom_word_serializer.sv
// -----------------------------------------------------------------------------
// Bench for rom_word_serializer. Two instances share all control inputs: one
// with a zero-latency ROM and one with a two-cycle ROM. Both streams are
// compared against the word sequence the transfer rules imply.
// -----------------------------------------------------------------------------
module tb_rom_word_serializer;

    localparam int AW = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic manual_en = 1'b0;
    logic [AW-1:0] manual_addr = '0;
    logic ser_ready = 1'b1;

    logic [DW-1:0] rom_mem [0:7];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    logic so [2];
    logic sv [2];
    logic ws [2];
    logic fs [2];
    logic bz [2];
    logic dn [2];
    logic [AW-1:0] a1 = '0;
    logic [AW-1:0] a2 = '0;

    always #5 clk = ~clk;

    // Zero-latency ROM for instance 0; instance 1 sees data two cycles late.
    assign rd[0] = rom_mem[ra[0]];
    assign rd[1] = rom_mem[a2];
    always @(posedge clk) begin
        a1 <= ra[1];
        a2 <= a1;
    end

    rom_word_serializer #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .manual_en(manual_en), .manual_addr(manual_addr),
        .rom_addr(ra[0]), .rom_data(rd[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .ser_ready(ser_ready),
        .word_sync(ws[0]), .frame_sync(fs[0]), .busy(bz[0]), .done(dn[0])
    );

    rom_word_serializer #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .manual_en(manual_en), .manual_addr(manual_addr),
        .rom_addr(ra[1]), .rom_data(rd[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .ser_ready(ser_ready),
        .word_sync(ws[1]), .frame_sync(fs[1]), .busy(bz[1]), .done(dn[1])
    );

    int checks = 0;
    int failures = 0;

    // Cycle numbering: the edge that samples start is edge 0, and cycle n is
    // the interval following edge n-1.
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncap [2];
    int ws_n [2];
    int fs_n [2];
    int done_n [2];
    int done_c [2];
    int last_acc [2];
    int busy_n [2];
    int first_fs [2];
    int inv_err [2];
    logic cap [2][256];
    logic pst [2];
    logic pso [2];
    logic psv [2];
    logic pws [2];
    logic pfs [2];

    // Monitor: sample outputs on the falling edge.
    always @(negedge clk) begin
        int rel;
        rel = cyc - t0 + 1;
        for (int k = 0; k < 2; k++) begin
            if (pst[k] && (so[k] !== pso[k] || sv[k] !== psv[k] ||
                           ws[k] !== pws[k] || fs[k] !== pfs[k]))
                inv_err[k]++;
            if (!sv[k] && so[k]) inv_err[k]++;
            if (fs[k] && !ws[k]) inv_err[k]++;
            if (sv[k] && ser_ready) begin
                if (ncap[k] < 256) cap[k][ncap[k]] = so[k];
                ncap[k]++;
                last_acc[k] = rel;
                if (ws[k]) ws_n[k]++;
                if (fs[k]) fs_n[k]++;
            end
            if (fs[k] && first_fs[k] < 0) first_fs[k] = rel;
            if (bz[k]) busy_n[k]++;
            if (dn[k]) begin
                done_n[k]++;
                done_c[k] = rel;
            end
            pst[k] = sv[k] && !ser_ready;
            pso[k] = so[k];
            psv[k] = sv[k];
            pws[k] = ws[k];
            pfs[k] = fs[k];
        end
    end

    typedef struct {
        bit man;
        int ad;
        bit rnd;
        int n_bits;
        int n_ws;
        int n_fs;
        int done0;
        int done2;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    function automatic string nm(input int k, input string s);
        return $sformatf("lat%0d_%s", (k == 0) ? 0 : 2, s);
    endfunction

    // Reference: bit idx of a transfer is bit (15 - idx%16) of the word the
    // transfer visits at position idx/16.
    function automatic logic exp_bit(input bit man, input int ad, input int idx);
        logic [DW-1:0] w;
        w = rom_mem[man ? ad : idx / DW];
        return w[DW-1 - (idx % DW)];
    endfunction

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            ncap[k] = 0; ws_n[k] = 0; fs_n[k] = 0; done_n[k] = 0;
            done_c[k] = -1; last_acc[k] = -1; busy_n[k] = 0;
            first_fs[k] = -1; inv_err[k] = 0; pst[k] = 1'b0;
        end
    endtask

    task automatic load_rom_pattern();
        for (int i = 0; i < 8; i++) rom_mem[i] = 16'hA5A0 | 16'(i);
    endtask

    // Run one transfer on both instances. start_bit/abort_bit >= 0 pulse
    // start/abort in the cycle where instance 0 presents that bit index.
    task automatic run_xfer(input vec_t v, input int start_bit, input int abort_bit);
        bit fired_s;
        bit finished;
        int mism;
        int exp_addr;
        fired_s = 0;
        finished = 0;
        clear_mon();
        manual_en = v.man;
        manual_addr = AW'(v.ad);
        start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        $display("xfer man=%0d addr=%0d rnd=%0d start_at=%0d abort_at=%0d",
                 v.man, v.ad, v.rnd, start_bit, abort_bit);
        for (int c = 0; c < 4000; c++) begin
            if (abort_bit < 0 && done_n[0] > 0 && done_n[1] > 0) begin
                finished = 1;
                break;
            end
            ser_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 1'b0;
            if (start_bit >= 0 && !fired_s && ncap[0] == start_bit) begin
                start = 1'b1;
                fired_s = 1;
            end
            if (abort_bit >= 0 && ncap[0] == abort_bit) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                chk("abort_valid_next", int'(sv[0]), 0);
                chk("abort_busy_next", int'(bz[0]), 0);
                chk("abort_done_next", int'(dn[0]), 0);
                chk("abort_busy_lat2", int'(bz[1]), 0);
                repeat (5) @(posedge clk);
                #1;
                chk("abort_no_done_lat0", done_n[0], 0);
                chk("abort_no_done_lat2", done_n[1], 0);
                chk("abort_addr_held", int'(ra[0]), 2);
                finished = 1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        ser_ready = 1'b1;
        if (!finished) begin
            chk("xfer_timeout", 0, 1);
            return;
        end
        if (abort_bit >= 0) return;
        exp_addr = v.man ? v.ad : 7;
        for (int k = 0; k < 2; k++) begin
            mism = 0;
            for (int i = 0; i < v.n_bits && i < 256; i++)
                if (cap[k][i] !== exp_bit(v.man, v.ad, i)) mism++;
            chk(nm(k, "nbits"), ncap[k], v.n_bits);
            chk(nm(k, "bit_mismatches"), mism, 0);
            chk(nm(k, "word_syncs"), ws_n[k], v.n_ws);
            chk(nm(k, "frame_syncs"), fs_n[k], v.n_fs);
            chk(nm(k, "done_pulses"), done_n[k], 1);
            chk(nm(k, "done_after_last_bit"), done_c[k], last_acc[k] + 1);
            chk(nm(k, "busy_cycles"), busy_n[k], done_c[k] - 1);
            chk(nm(k, "stall_and_idle_rules"), inv_err[k], 0);
            chk(nm(k, "final_addr"), int'(ra[k]), exp_addr);
            if ((k == 0 ? v.done0 : v.done2) > 0)
                chk(nm(k, "done_cycle"), done_c[k], (k == 0) ? v.done0 : v.done2);
            if (!v.rnd && !v.man)
                chk(nm(k, "frame_sync_cycle"), first_fs[k], (k == 0) ? 2 : 4);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk(nm(k, {tag, "_rom_addr"}), int'(ra[k]), 0);
            chk(nm(k, {tag, "_ser_out"}), int'(so[k]), 0);
            chk(nm(k, {tag, "_ser_valid"}), int'(sv[k]), 0);
            chk(nm(k, {tag, "_word_sync"}), int'(ws[k]), 0);
            chk(nm(k, {tag, "_frame_sync"}), int'(fs[k]), 0);
            chk(nm(k, {tag, "_busy"}), int'(bz[k]), 0);
            chk(nm(k, {tag, "_done"}), int'(dn[k]), 0);
        end
    endtask

    initial begin
        vec_t tbl [6];
        vec_t v;
        tbl[0] = '{man: 0, ad: 0, rnd: 0, n_bits: 128, n_ws: 8, n_fs: 1, done0: 137, done2: 153};
        tbl[1] = '{man: 1, ad: 5, rnd: 0, n_bits: 16,  n_ws: 1, n_fs: 0, done0: 18,  done2: 20};
        tbl[2] = '{man: 1, ad: 0, rnd: 0, n_bits: 16,  n_ws: 1, n_fs: 0, done0: 18,  done2: 20};
        tbl[3] = '{man: 1, ad: 7, rnd: 0, n_bits: 16,  n_ws: 1, n_fs: 0, done0: 18,  done2: 20};
        tbl[4] = '{man: 0, ad: 0, rnd: 1, n_bits: 128, n_ws: 8, n_fs: 1, done0: -1,  done2: -1};
        tbl[5] = '{man: 1, ad: 2, rnd: 1, n_bits: 16,  n_ws: 1, n_fs: 0, done0: -1,  done2: -1};

        load_rom_pattern();
        clear_mon();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_xfer(tbl[i], -1, -1);

        // Abort while instance 0 presents bit 7 of word 2, then restart.
        run_xfer(tbl[0], -1, 2 * DW + 7);
        run_xfer(tbl[0], -1, -1);

        // start pulsed during word 4 must be ignored.
        run_xfer(tbl[0], 4 * DW + 3, -1);

        // Reset during the first fetch cycle.
        clear_mon();
        manual_en = 1'b1;
        manual_addr = 3'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("fetch_busy_before_rst", int'(bz[0]), 1);
        chk("fetch_addr_before_rst", int'(ra[0]), 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero("midrst");
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done_lat0", done_n[0], 0);
        chk("midrst_no_done_lat2", done_n[1], 0);
        run_xfer(tbl[1], -1, -1);

        // Random ROM contents, modes and back-pressure.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) rom_mem[i] = 16'($urandom);
            v.man = 1'($urandom_range(0, 1));
            v.ad = $urandom_range(0, 7);
            v.rnd = 1;
            v.n_bits = v.man ? 16 : 128;
            v.n_ws = v.man ? 1 : 8;
            v.n_fs = v.man ? 0 : 1;
            v.done0 = -1;
            v.done2 = -1;
            run_xfer(v, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
